execute_muldiv: RTL
===================

// Module: execute_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the single-cycle execute stage.
//  Accepts one M-extension op (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over a
//  valid/ready handshake and computes it over several cycles.
//  Returns one pulsed writeback (rd, x_rd). The pipeline stalls on busy.
// PARAMETERS
//  XLEN     32  operand/result width; also the iteration count (must be even, >=8)
//  CNT_W     6  iteration counter width; must be >= clog2(XLEN)+1
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     synchronous reset, active-high
//  flush     in   1     abort in-flight op (branch/jump redirect)
//  in_vld    in   1     op request valid
//  in_rdy    out  1     = (state==IDLE) && !rst; accept when in_vld&&in_rdy
//  op        in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  x_rs1     in   XLEN  operand A (dividend / multiplicand)
//  x_rs2     in   XLEN  operand B (divisor / multiplier)
//  rd        in   5     destination register tag, carried through
//  busy      out  1     1 while state != IDLE
//  out_vld   out  1     one-cycle result strobe, no backpressure
//  out_rd    out  5     destination tag of result
//  out_x_rd  out  XLEN  result value
// BEHAVIOUR
//  Reset: state=IDLE, out_vld=0, out_rd=0, out_x_rd=0, busy=0, count=0.
//  FSM: IDLE -> CALC on accept; CALC -> DONE when count==XLEN-1; DONE -> IDLE.
//    Special-case divides go IDLE -> DONE directly.
//  Accept (cycle T): latch op, rd, operand magnitudes and sign flags; count=0.
//  Signedness: MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; rest unsigned.
//  MUL: shift-add over 2*XLEN product of magnitudes, one bit per CALC cycle.
//    Negate product if signs differ.
//    MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
//  DIV: restoring shift-subtract, one quotient bit per CALC cycle.
//    Quotient sign = sA^sB (signed ops only); remainder sign = sA.
//  Latency: out_vld asserted in cycle T+XLEN+1 (33 for XLEN=32), exactly one cycle.
//    Back-to-back: next accept is possible in cycle T+XLEN+2.
//  Special cases are decided at accept; out_vld is asserted at T+1:
//    - divide by zero: DIV/DIVU -> all ones; REM/REMU -> x_rs1.
//    - signed overflow (x_rs1 = -2^(XLEN-1), x_rs2 = -1): DIV -> x_rs1; REM -> 0.
//  out_rd/out_x_rd update only with out_vld and hold their value otherwise.
//  rd==0 is still computed and strobed; writeback discards it.
//  flush: any state -> IDLE next cycle, and out_vld stays 0 that cycle.
//    If flush arrives in the same cycle as out_vld, that strobe still stands
//    (the result was registered previously).
//  flush && in_vld in the same cycle: flush wins and nothing is accepted.
//  rst mid-operation: same as flush; additionally all outputs return to reset values.
//  in_vld while busy: ignored. The requester must hold in_vld until in_rdy.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: multiply ops use a combinational XLEN x XLEN
//    product, registered once. Flow is IDLE -> CALC (1 cycle) -> DONE, so
//    out_vld arrives at T+2. Divide is unchanged.
//  Not defined: iterative multiply, latency T+XLEN+1, as above.
// TESTING
//  MUL 7 x -3 -> out_x_rd=0xFFFFFFEB at T+33 (T+2 with FAST_MUL), out_rd echoes rd=5.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all at T+33.
//  DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5 at T+1;
//    DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, at T+1.
//  Accept DIVU, pulse flush at T+10 -> no out_vld ever, in_rdy=1 at T+11;
//    a new op accepted at T+11 completes normally.
//  Hold in_vld with two ops back-to-back -> second accepted at T+34; in_rdy=0 and busy=1 in between;
//    rst at T+5 -> out_vld=0, busy=0 at T+6.

Source files
------------

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready accept and pulsed writeback.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module execute_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] x_rs1,
    input  logic [XLEN-1:0] x_rs2,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            out_vld,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_x_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                out_vld_q, out_vld_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [XLEN-1:0]     out_x_rd_q, out_x_rd_d;

    logic                accept;
    logic                sgn_a, sgn_b, sa_in, sb_in;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     spec_val;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       r_sh, diff;
    logic                ge;
    logic [2*XLEN-1:0]   div_nxt;
    logic [2*XLEN-1:0]   prod, mul_s;
    logic [XLEN-1:0]     quo, rem, mul_res, div_res, result;
    logic                last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            opd_q      <= '0;
            acc_q      <= '0;
            out_vld_q  <= 1'b0;
            out_rd_q   <= '0;
            out_x_rd_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            opd_q      <= opd_d;
            acc_q      <= acc_d;
            out_vld_q  <= out_vld_d;
            out_rd_q   <= out_rd_d;
            out_x_rd_q <= out_x_rd_d;
        end
    end

    // Operand decode at accept
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (op)
            3'd1, 3'd4, 3'd6: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'd2:    sgn_a = 1'b1;
            default: ;
        endcase
        sa_in    = sgn_a & x_rs1[XLEN-1];
        sb_in    = sgn_b & x_rs2[XLEN-1];
        mag_a    = sa_in ? -x_rs1 : x_rs1;
        mag_b    = sb_in ? -x_rs2 : x_rs2;
        div_zero = op[2] && (x_rs2 == '0);
        div_ovf  = op[2] && !op[0]
                   && (x_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (x_rs2 == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            spec_val = op[1] ? x_rs1 : '1;
        else
            spec_val = op[1] ? '0 : x_rs1;
    end

    // One shift-add or shift-subtract step, plus final sign fix-up
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
        r_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = r_sh - {1'b0, opd_q};
        ge      = !diff[XLEN];
        div_nxt = {(ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0]),
                   acc_q[XLEN-2:0], ge};
`ifdef MULDIV_FAST_MUL_EN
        prod = {{XLEN{1'b0}}, opd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        last = !op_q[2] || (count_q == CNT_W'(XLEN-1));
`else
        prod = mul_nxt;
        last = (count_q == CNT_W'(XLEN-1));
`endif
        mul_s   = (sa_q ^ sb_q) ? -prod : prod;
        mul_res = (op_q[1:0] == 2'd0) ? mul_s[XLEN-1:0]
                                      : mul_s[2*XLEN-1:XLEN];
        quo     = div_nxt[XLEN-1:0];
        rem     = div_nxt[2*XLEN-1:XLEN];
        if (op_q[1])
            div_res = sa_q ? -rem : rem;
        else
            div_res = (sa_q ^ sb_q) ? -quo : quo;
        result  = op_q[2] ? div_res : mul_res;
    end

    assign accept = in_vld && in_rdy && !flush;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (last)   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // Datapath and result registers
    always_comb begin
        count_d    = count_q;
        op_d       = op_q;
        rd_d       = rd_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        opd_d      = opd_q;
        acc_d      = acc_q;
        out_vld_d  = 1'b0;
        out_rd_d   = out_rd_q;
        out_x_rd_d = out_x_rd_q;
        if (flush) begin
            out_vld_d = 1'b0;
        end else if (state_q == IDLE && accept) begin
            count_d = '0;
            op_d    = op;
            rd_d    = rd;
            sa_d    = sa_in;
            sb_d    = sb_in;
            opd_d   = op[2] ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            if (special) begin
                out_vld_d  = 1'b1;
                out_rd_d   = rd;
                out_x_rd_d = spec_val;
            end
        end else if (state_q == CALC) begin
            count_d = count_q + CNT_W'(1);
            acc_d   = op_q[2] ? div_nxt : mul_nxt;
            if (last) begin
                out_vld_d  = 1'b1;
                out_rd_d   = rd_q;
                out_x_rd_d = result;
            end
        end
    end

    // Handshake outputs
    always_comb begin
        in_rdy = (state_q == IDLE) && !rst;
        busy   = (state_q != IDLE);
    end

    assign out_vld  = out_vld_q;
    assign out_rd   = out_rd_q;
    assign out_x_rd = out_x_rd_q;

endmodule
